// File: rtl/tmds_channel_decoder_if.sv
// Word-level bus between a TMDS deserializer and its channel decoder.
// The deserializer side is the master; the decoder is the slave.
interface tmds_channel_decoder_if;
  logic       din_valid;
  logic [9:0] din;
  logic       bitslip;
  logic       aligned;
  logic       dout_valid;
  logic [7:0] dout;
  logic [1:0] ctl;
  logic       de;

  modport master (
    output din_valid,
    output din,
    input  bitslip,
    input  aligned,
    input  dout_valid,
    input  dout,
    input  ctl,
    input  de
  );

  modport slave (
    input  din_valid,
    input  din,
    output bitslip,
    output aligned,
    output dout_valid,
    output dout,
    output ctl,
    output de
  );
endinterface

// File: rtl/tmds_channel_decoder.sv
// Decodes one TMDS channel: hunts for the word boundary with bitslip requests,
// then decodes control tokens and video data through a two-stage pipeline.
module tmds_channel_decoder #(
  parameter int TOKEN_COUNT = 8,
  parameter int WINDOW      = 4096,
  parameter int SLIP_WAIT   = 16
) (
  input  logic                  clkin,
  input  logic                  reset,
  tmds_channel_decoder_if.slave bus
);

  localparam int RUN_W  = $clog2(TOKEN_COUNT + 1);
  localparam int WIN_W  = $clog2(WINDOW) + 1;
  localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(TOKEN_COUNT);
  localparam logic [WIN_W-1:0]  WIN_LIMIT = WIN_W'(WINDOW);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED
  } state_t;

  typedef struct packed {
    logic       is_token;
    logic [1:0] ctl;
  } token_t;

  function automatic token_t classify(input logic [9:0] word);
    token_t t;
    t.is_token = 1'b1;
    t.ctl      = 2'b00;
    case (word)
      10'h354: t.ctl = 2'b00;
      10'h0AB: t.ctl = 2'b01;
      10'h154: t.ctl = 2'b10;
      10'h2AB: t.ctl = 2'b11;
      default: t.is_token = 1'b0;
    endcase
    return t;
  endfunction

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  function automatic logic [7:0] decode_data(input logic [9:0] word);
    logic [7:0] d;
    logic [7:0] q;
    d    = word[9] ? ~word[7:0] : word[7:0];
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [9:0]        s1_word_q,  s1_word_d;
  token_t            s1_token_q, s1_token_d;

  logic              dout_valid_q, dout_valid_d;
  logic [7:0]        dout_q,       dout_d;
  logic [1:0]        ctl_q,        ctl_d;
  logic              de_q,         de_d;

  state_t            state_q, state_d;
  logic [RUN_W-1:0]  run_q,   run_d;
  logic [WIN_W-1:0]  win_q,   win_d;
  logic [WAIT_W-1:0] wait_q,  wait_d;

  logic [RUN_W-1:0]  run_next;
  logic [WIN_W-1:0]  win_next;
  logic              count_word;
  logic              run_hit;
  logic              win_hit;

  // Stage 1 captures the word and its token classification; data holds on gaps.
  always_comb begin
    s1_valid_d = bus.din_valid;
    s1_word_d  = s1_word_q;
    s1_token_d = s1_token_q;
    if (bus.din_valid) begin
      s1_word_d  = bus.din;
      s1_token_d = classify(bus.din);
    end
  end

  always_comb begin
    dout_valid_d = s1_valid_q;
    dout_d       = dout_q;
    ctl_d        = ctl_q;
    de_d         = de_q;
    if (s1_valid_q) begin
      if (s1_token_q.is_token) begin
        de_d  = 1'b0;
        ctl_d = s1_token_q.ctl;
      end else begin
        de_d   = 1'b1;
        dout_d = decode_data(s1_word_q);
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_word_q    <= '0;
      s1_token_q   <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      ctl_q        <= '0;
      de_q         <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_word_q    <= s1_word_d;
      s1_token_q   <= s1_token_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      ctl_q        <= ctl_d;
      de_q         <= de_d;
    end
  end

  // Counter candidates for the word currently in stage 1.
  always_comb begin
    count_word = s1_valid_q && ((state_q == ST_SEARCH) || (state_q == ST_LOCKED));
    win_next   = win_q + 1'b1;
    run_next   = '0;
    if (s1_token_q.is_token) begin
      run_next = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    end
    run_hit = (run_next == RUN_MAX);
    win_hit = (win_next == WIN_LIMIT);
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    win_d   = win_q;
    wait_d  = wait_q;
    case (state_q)
      ST_SEARCH, ST_LOCKED: begin
        if (count_word) begin
          run_d = run_next;
          win_d = win_next;
          // A qualifying token run takes priority over an expiring window.
          if (run_hit) begin
            state_d = ST_LOCKED;
            win_d   = '0;
          end else if (win_hit) begin
            state_d = ST_SLIP;
          end
        end
      end
      ST_SLIP: begin
        run_d   = '0;
        win_d   = '0;
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        run_d = '0;
        win_d = '0;
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = ST_SEARCH;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        run_d   = '0;
        win_d   = '0;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q <= ST_SEARCH;
      run_q   <= '0;
      win_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      win_q   <= win_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.bitslip    = (state_q == ST_SLIP);
  assign bus.aligned    = (state_q == ST_LOCKED);
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout       = dout_q;
  assign bus.ctl        = ctl_q;
  assign bus.de         = de_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: vector table, hand-written
// alignment sequences and a randomized run against a behavioural model.
module tb_tmds_channel_decoder;

  localparam int TOKEN_COUNT = 8;
  localparam int WINDOW      = 64;
  localparam int SLIP_WAIT   = 4;
  localparam int NVEC        = 17;

  localparam logic [9:0] TOKENS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  logic clkin = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic model_on = 1'b0;

  always #5 clkin = ~clkin;

  tmds_channel_decoder_if bus();

  tmds_channel_decoder #(
    .TOKEN_COUNT(TOKEN_COUNT),
    .WINDOW     (WINDOW),
    .SLIP_WAIT  (SLIP_WAIT)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        s1_valid;
    logic [9:0]  s1_word;
    logic        valid;
    logic [7:0]  dout;
    logic [1:0]  ctl;
    logic        de;
    logic [31:0] run;
    logic [31:0] win;
    logic [31:0] quiet;
    logic        locked;
    logic        slip;
  } model_t;

  typedef struct {
    logic [9:0] din;
    logic [7:0] dout;
    logic [1:0] ctl;
    logic       de;
  } vec_t;

  model_t m = '0;
  vec_t   vecs [NVEC];

  function automatic int tokenIndex(input logic [9:0] w);
    for (int i = 0; i < 4; i++) begin
      if (w == TOKENS[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] refDecode(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] q;
    d = w[9] ? ~w[7:0] : w[7:0];
    q = d ^ {d[6:0], 1'b0};
    if (!w[8]) q = q ^ 8'hFE;
    return q;
  endfunction

  // Alignment behaviour: count valid words, lock on a token run, and after
  // a window expires stay quiet for the slip cycle plus the wait period.
  function automatic model_t modelStep(input model_t c, input logic rst,
                                       input logic v, input logic [9:0] w);
    model_t n;
    int     ti;
    if (rst) return '0;
    n      = c;
    n.slip = 1'b0;
    ti     = tokenIndex(c.s1_word);
    if (c.quiet != 0) begin
      n.quiet = c.quiet - 1;
    end else if (c.s1_valid) begin
      n.run = (ti >= 0) ? ((c.run < TOKEN_COUNT) ? c.run + 1 : c.run) : 0;
      n.win = c.win + 1;
      if (n.run == TOKEN_COUNT) begin
        n.locked = 1'b1;
        n.win    = 0;
      end else if (n.win == WINDOW) begin
        n.locked = 1'b0;
        n.slip   = 1'b1;
        n.quiet  = SLIP_WAIT + 1;
        n.run    = 0;
        n.win    = 0;
      end
    end
    n.valid = c.s1_valid;
    if (c.s1_valid) begin
      if (ti >= 0) begin
        n.de  = 1'b0;
        n.ctl = 2'(ti);
      end else begin
        n.de   = 1'b1;
        n.dout = refDecode(c.s1_word);
      end
    end
    n.s1_valid = v;
    if (v) n.s1_word = w;
    return n;
  endfunction

  function automatic logic [9:0] rotWord(input int off);
    logic [9:0] t;
    logic [9:0] w;
    t = 10'h354;
    for (int b = 0; b < 10; b++) w[b] = t[(off + b) % 10];
    return w;
  endfunction

  function automatic logic [9:0] randomData();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    while (tokenIndex(w) >= 0) w = 10'($urandom_range(0, 1023));
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [9:0] w);
    bus.din_valid = v;
    bus.din       = w;
    @(negedge clkin);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 10'h000);
    reset = 1'b0;
    checkOutput("rst_bitslip",    bus.bitslip,    0);
    checkOutput("rst_aligned",    bus.aligned,    0);
    checkOutput("rst_dout_valid", bus.dout_valid, 0);
    checkOutput("rst_dout",       bus.dout,       0);
    checkOutput("rst_ctl",        bus.ctl,        0);
    checkOutput("rst_de",         bus.de,         0);
  endtask

  always @(posedge clkin) m <= modelStep(m, reset, bus.din_valid, bus.din);

  always @(negedge clkin) begin
    if (model_on) begin
      checkOutput("cycle_model",
                  {bus.bitslip, bus.aligned, bus.dout_valid, bus.de, bus.ctl, bus.dout},
                  {m.slip, m.locked, m.valid, m.de, m.ctl, m.dout});
    end
  end

  initial begin
    logic seen_slip;
    int   off;
    int   n_pulse;
    int   lock_call;
    int   pulse_at [4];
    int   burst;
    logic v;
    logic [9:0] w;

    bus.din_valid = 1'b0;
    bus.din       = '0;
    repeat (2) @(negedge clkin);
    model_on = 1'b1;
    doReset();

    seen_slip = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 10'h354);
      seen_slip |= bus.bitslip;
    end
    checkOutput("idle_bitslip",    seen_slip,      0);
    checkOutput("idle_aligned",    bus.aligned,    0);
    checkOutput("idle_dout_valid", bus.dout_valid, 0);

    for (int i = 0; i < 8; i++) vecs[i] = '{10'h354, 8'h00, 2'b00, 1'b0};
    vecs[8]  = '{10'h2AB, 8'h00, 2'b11, 1'b0};
    vecs[9]  = '{10'h300, 8'h01, 2'b11, 1'b1};
    vecs[10] = '{10'h100, 8'h00, 2'b11, 1'b1};
    vecs[11] = '{10'h000, 8'hFE, 2'b11, 1'b1};
    vecs[12] = '{10'h0AB, 8'hFE, 2'b01, 1'b0};
    vecs[13] = '{10'h1FF, 8'h01, 2'b01, 1'b1};
    vecs[14] = '{10'h154, 8'h01, 2'b10, 1'b0};
    vecs[15] = '{10'h0FF, 8'hFF, 2'b10, 1'b1};
    vecs[16] = '{10'h2AA, 8'h01, 2'b10, 1'b1};

    for (int i = 0; i <= NVEC; i++) begin
      if (i < NVEC) applyStimulus(1'b1, vecs[i].din);
      else          applyStimulus(1'b0, 10'h000);
      if (i == TOKEN_COUNT - 1) checkOutput("vec_pre_lock", bus.aligned, 0);
      if (i == TOKEN_COUNT)     checkOutput("vec_lock",     bus.aligned, 1);
      if (i >= 1) begin
        checkOutput($sformatf("vec%0d_valid", i - 1), bus.dout_valid, 1);
        checkOutput($sformatf("vec%0d_dout",  i - 1), bus.dout, vecs[i-1].dout);
        checkOutput($sformatf("vec%0d_ctl",   i - 1), bus.ctl,  vecs[i-1].ctl);
        checkOutput($sformatf("vec%0d_de",    i - 1), bus.de,   vecs[i-1].de);
      end
    end

    // Tokens separated by idle cycles still form a run; one data word breaks it.
    doReset();
    for (int k = 0; k < TOKEN_COUNT - 1; k++) begin
      applyStimulus(1'b1, 10'h354);
      applyStimulus(1'b0, 10'h000);
    end
    applyStimulus(1'b1, 10'h100);
    for (int k = 0; k < TOKEN_COUNT - 1; k++) begin
      applyStimulus(1'b1, 10'h0AB);
      applyStimulus(1'b0, 10'h000);
    end
    applyStimulus(1'b0, 10'h000);
    checkOutput("gap_run_cleared", bus.aligned, 0);
    applyStimulus(1'b1, 10'h354);
    applyStimulus(1'b0, 10'h000);
    applyStimulus(1'b0, 10'h000);
    checkOutput("gap_lock", bus.aligned, 1);

    // Lock loss: a full window of data with an isolated 7-token run inside.
    for (int k = 1; k <= WINDOW + 2; k++) begin
      w = (k >= 20 && k < 20 + TOKEN_COUNT - 1) ? 10'h354 : randomData();
      applyStimulus(1'b1, w);
      if (k == WINDOW) begin
        checkOutput("loss_hold_aligned", bus.aligned, 1);
        checkOutput("loss_hold_bitslip", bus.bitslip, 0);
      end
      if (k == WINDOW + 1) begin
        checkOutput("loss_aligned_drop", bus.aligned, 0);
        checkOutput("loss_bitslip",      bus.bitslip, 1);
      end
      if (k == WINDOW + 2) checkOutput("loss_bitslip_single", bus.bitslip, 0);
    end
    applyStimulus(1'b1, randomData());
    doReset();

    // After a mid-wait reset the window restarts from zero.
    for (int k = 1; k <= WINDOW + 1; k++) begin
      applyStimulus(1'b1, randomData());
      if (k == WINDOW)     checkOutput("post_rst_no_slip", bus.bitslip, 0);
      if (k == WINDOW + 1) checkOutput("post_rst_slip",    bus.bitslip, 1);
    end

    // Misaligned serial stream: the bench's deserializer shifts on each pulse.
    doReset();
    off       = 7;
    n_pulse   = 0;
    lock_call = -1;
    for (int i = 0; i < 4; i++) pulse_at[i] = 0;
    for (int call = 1; call <= 400 && lock_call < 0; call++) begin
      applyStimulus(1'b1, rotWord(off));
      if (bus.bitslip) begin
        if (n_pulse < 4) pulse_at[n_pulse] = call;
        n_pulse++;
        off = (off + 1) % 10;
      end
      if (bus.aligned) lock_call = call;
    end
    checkOutput("mis_pulses",      n_pulse,     3);
    checkOutput("mis_first_pulse", pulse_at[0], WINDOW + 1);
    checkOutput("mis_interval1",   pulse_at[1] - pulse_at[0], WINDOW + SLIP_WAIT + 1);
    checkOutput("mis_interval2",   pulse_at[2] - pulse_at[1], WINDOW + SLIP_WAIT + 1);
    checkOutput("mis_lock_delay",  lock_call - pulse_at[2], TOKEN_COUNT + SLIP_WAIT + 1);

    // Randomized traffic with token bursts and occasional resets.
    doReset();
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      v     = ($urandom_range(0, 3) != 0);
      if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(4, 12);
      if (burst > 0) w = TOKENS[$urandom_range(0, 3)];
      else           w = 10'($urandom_range(0, 1023));
      if (v && burst > 0) burst--;
      applyStimulus(v, w);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 10'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the TMDS transmit clocking path; decodes one TMDS channel at pixel rate.
- Input: 10-bit parallel words from a deserializer.
- Function: aligns word boundaries by issuing bitslip requests, then produces 8-bit video data, 2-bit control and data-enable.
- Three instances (B/G/R) sit between the deserializers and the video timing recovery logic.

Parameters:
TOKEN_COUNT, 8, consecutive control tokens required to declare alignment
WINDOW, 4096, valid words allowed without a qualifying token run before slipping or losing lock
SLIP_WAIT, 16, clkin cycles to wait after a bitslip pulse before searching again

Ports:
clkin  in  1  pixel clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
din_valid  in  1  din carries a valid word this cycle
din  in  10  TMDS word, bit 0 first on the wire
bitslip  out  1  one-cycle request to the deserializer to shift the word boundary by one bit
aligned  out  1  word boundary locked
dout_valid  out  1  dout/ctl/de valid
dout  out  8  decoded pixel data
ctl  out  2  decoded control bits {c1,c0}; held when de=1
de  out  1  1 = data period, 0 = control token

Behaviour:
- Reset: the following are 0: bitslip, aligned, dout_valid, dout, ctl, de. State = SEARCH. All counters are 0.
- Pipeline: 2 stages, latency 2 cycles from din to outputs.
  - Stage 1 registers din and classifies it as token or non-token.
  - Stage 2 registers the decode result. dout_valid is din_valid delayed 2 cycles.
  - When din_valid=0 the stages still advance with valid=0; the data fields hold their previous values.
- Control tokens (de=0):
  - 0x354 -> ctl=00
  - 0x0AB -> ctl=01
  - 0x154 -> ctl=10
  - 0x2AB -> ctl=11
- Data decode (de=1; ctl holds its last value; dout holds its last value on token words):
  - d = din[9] ? ~din[7:0] : din[7:0]
  - dout[0] = d[0]
  - dout[i] = d[i] ^ d[i-1] when din[8]=1, else ~(d[i] ^ d[i-1]), for i=1..7
- Counters, evaluated on stage-1 valid words only:
  - run_cnt: increments on a token word, clears on a non-token word, saturates at TOKEN_COUNT.
  - win_cnt: increments on every valid word, width clog2(WINDOW)+1.
- FSM:
  - SEARCH:
    - run_cnt reaches TOKEN_COUNT -> LOCKED; aligned=1 the next cycle; win_cnt cleared.
    - Otherwise win_cnt reaches WINDOW -> SLIP.
    - If both occur on the same word, LOCKED wins.
  - SLIP: bitslip=1 for exactly one cycle; counters cleared -> WAIT.
  - WAIT:
    - Count SLIP_WAIT clkin cycles regardless of din_valid -> SEARCH.
    - Words arriving during WAIT do not update counters.
  - LOCKED:
    - aligned=1.
    - Each run reaching TOKEN_COUNT clears win_cnt.
    - win_cnt reaching WINDOW -> SLIP; aligned drops to 0 the same cycle bitslip rises.
- bitslip is asserted only in SLIP and never in two consecutive cycles.
- Decode runs in every state; outputs are not gated by aligned.
- reset asserted mid-operation, including during SLIP or WAIT: next cycle all outputs are 0 and state is SEARCH; a bitslip pulse in flight is cancelled.

Test Plan:
- Reset, then idle with din_valid=0 for 20 cycles -> bitslip, aligned and dout_valid stay 0; no counter advances.
- Aligned token stream: 8 consecutive valid 0x354 words -> aligned=1 one cycle after the 8th word registers in stage 1; outputs show de=0, ctl=00, dout_valid=1 with 2-cycle latency. Then 0x2AB -> ctl=11.
- Data decode, one case per word; each check de=1, ctl unchanged from previous token:
  - din=0x300 -> dout=0x01
  - din=0x100 -> dout=0x00
  - din=0x000 -> dout=0xFE
- Misaligned stream (0x354 rotated by 3 bits, repeating), WINDOW=64, SLIP_WAIT=4 -> first bitslip pulse after 64 valid words; pulses then repeat every 64 words + 4 wait cycles. The model rotates on each pulse; after the 3rd slip plus 8 tokens, aligned=1.
- Lock loss: after lock, drive WINDOW valid data words with no token run -> aligned falls and bitslip pulses in the same cycle. An isolated run of 7 tokens inside the window does not restart the window.
- Reset mid-WAIT and din_valid gaps: reset asserted during WAIT -> state SEARCH, bitslip=0, counters 0. Tokens interleaved with din_valid=0 cycles still count as consecutive; one non-token valid word clears run_cnt.
